// File: rtl/rv_dmem_ctrl.sv
// rv_dmem_ctrl: RV32 data-memory controller with an internal word RAM.
// Handles lb/lh/lw/lbu/lhu and sb/sh/sw with byte strobes, a configurable
// load latency and a single-outstanding valid/ready request handshake.
//
// Ports:
//   clk, reset            - clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   - request handshake; accept on valid & ready
//   req_we                - 1 = store, 0 = load
//   req_funct3            - RISC-V load/store funct3
//   req_addr              - byte address (AW bits)
//   req_wdata             - right-aligned store data
//   rsp_valid             - one-cycle response pulse
//   rsp_rdata             - extended load data (0 for stores/errors/idle)
//   rsp_error             - misaligned, illegal funct3 or out-of-range access
module rv_dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_error
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          out_of_range;
  logic          misaligned;
  logic          illegal;
  logic          req_err;
  logic [IW-1:0] idx;
  logic [3:0]    strb;
  logic [31:0]   wlanes;
  logic [31:0]   word;
  logic [15:0]   lane;
  logic [31:0]   load_val;

  assign req_ready    = (state_q != WAIT);
  assign accept       = req_valid & req_ready;
  assign idx          = req_addr[IW+1:2];
  // Any address bit above the word-index field lies outside the array.
  assign out_of_range = |(req_addr >> (IW + 2));

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (req_we) illegal = (req_funct3 > 3'd2);
    else        illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign req_err = out_of_range | misaligned | illegal;

  // Store lanes are replicated so the strobe alone picks the target bytes.
  always_comb begin
    strb   = 4'b0000;
    wlanes = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        strb   = 4'b0001 << req_addr[1:0];
        wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb   = 4'b0011 << {req_addr[1], 1'b0};
        wlanes = {2{req_wdata[15:0]}};
      end
      2'b10:   strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  // The word is read and lane-selected at the accept edge; the extended
  // result then waits in rdata_q for the remaining latency.
  assign word = mem[idx];
  assign lane = 16'(word >> {req_addr[1:0], 3'b000});

  always_comb begin
    case (req_funct3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'h000000, lane[7:0]};
      3'b101:  load_val = {16'h0000, lane};
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RESP;
      end
      default: begin
        if (accept) begin
          err_d   = req_err;
          rdata_d = (req_we || req_err) ? '0 : load_val;
          if (!req_we && !req_err && READ_LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = 3'(READ_LATENCY - 1);
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_error = rsp_valid & err_q;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Testbench for rv_dmem_ctrl: three instances with READ_LATENCY 1, 3 and 4,
// directed scenarios plus randomized traffic against a byte-array model.
module tb_rv_dmem_ctrl;

  localparam int unsigned ND    = 3;
  localparam int unsigned DEPTH = 256;

  localparam logic [2:0]  LANE_F3  [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
  localparam logic [31:0] LANE_AD  [5] = '{32'h40, 32'h42, 32'h42, 32'h40, 32'h42};
  localparam logic [31:0] LANE_EXP [5] = '{32'h11ADBEEF, 32'hFFFFFFAD, 32'h000000AD,
                                           32'hFFFFBEEF, 32'h000011AD};
  localparam logic [2:0]  LEGAL_LD [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [ND];
  logic        req_valid [ND];
  logic        req_ready [ND];
  logic        req_we    [ND];
  logic [2:0]  req_f3    [ND];
  logic [31:0] req_addr  [ND];
  logic [31:0] req_wdata [ND];
  logic        rsp_valid [ND];
  logic [31:0] rsp_rdata [ND];
  logic        rsp_error [ND];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference memory: plain byte array per instance.
  logic [7:0]  mb [ND][4*DEPTH];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    rv_dmem_ctrl #(
      .DEPTH_WORDS (DEPTH),
      .READ_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .AW          (32)
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_funct3(req_f3[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_error (rsp_error[g])
    );
  end

  function automatic int unsigned lat_of(input int unsigned d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic int unsigned acc_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  // Model of one access: decides error, applies stores, returns load data.
  task automatic ref_access(input int unsigned d, input logic we, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic e, output logic [31:0] r);
    int unsigned sz;
    logic [63:0] v;
    logic        ill;
    sz  = acc_size(f);
    v   = '0;
    ill = we ? (f > 3'd2) : (f == 3'd3 || f >= 3'd6);
    e   = ill || (a >= 32'(4 * DEPTH)) || ((a % sz) != 0);
    r   = '0;
    if (e) return;
    if (we) begin
      for (int unsigned i = 0; i < sz; i++) mb[d][a + i] = wd[8*i +: 8];
    end else begin
      for (int unsigned i = 0; i < sz; i++) v = v | (64'(mb[d][a + i]) << (8 * i));
      if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
      r = v[31:0];
    end
  endtask

  // Drives one request and observes its response; entered and left #1 after an edge.
  task automatic xact(input int unsigned d, input logic we, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int unsigned lat, output logic err, output logic [31:0] data,
                      output logic gate_ok);
    logic acc;
    acc     = 1'b0;
    lat     = 999;
    err     = 1'b0;
    data    = '0;
    gate_ok = 1'b1;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_f3[d]    = f;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    for (int unsigned i = 0; i < 20; i++) begin
      acc = req_ready[d];
      @(posedge clk); #1;
      if (acc) break;
    end
    req_valid[d] = 1'b0;
    if (!acc) return;
    for (int unsigned c = 1; c <= 8; c++) begin
      if (rsp_valid[d]) begin
        lat  = c;
        err  = rsp_error[d];
        data = rsp_rdata[d];
        return;
      end
      if (req_ready[d] || rsp_error[d] || rsp_rdata[d] != '0) gate_ok = 1'b0;
      if (c < 8) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    for (int unsigned d = 0; d < ND; d++) begin
      n_total++;
      if ({req_ready[d], rsp_valid[d], rsp_error[d], rsp_rdata[d]} !== {3'b100, 32'h0}) begin
        $display("FAIL reset_state dut%0d: got rdy/vld/err/data %b%b%b %h expected 100 0",
                 d, req_ready[d], rsp_valid[d], rsp_error[d], rsp_rdata[d]);
      end else n_pass++;
    end
  endtask

  task automatic test_store_load();
    int unsigned lat;
    logic e, err, ok;
    logic [31:0] r, data;
    ref_access(0, 1'b1, 3'd2, 32'h40, 32'hDEADBEEF, e, r);
    xact(0, 1'b1, 3'd2, 32'h40, 32'hDEADBEEF, lat, err, data, ok);
    n_total++;
    if ({lat, err, data} !== {32'd1, 1'b0, 32'h0}) begin
      $display("FAIL sw_ack: got lat %0d err %b data %h expected lat 1 err 0 data 0", lat, err, data);
    end else n_pass++;
    ref_access(0, 1'b0, 3'd2, 32'h40, 32'h0, e, r);
    xact(0, 1'b0, 3'd2, 32'h40, 32'h0, lat, err, data, ok);
    n_total++;
    if ({lat, err, data} !== {32'd1, 1'b0, 32'hDEADBEEF}) begin
      $display("FAIL lw_l1: got lat %0d err %b data %h expected lat 1 err 0 data deadbeef", lat, err, data);
    end else n_pass++;
  endtask

  task automatic test_lanes();
    int unsigned lat;
    logic e, err, ok;
    logic [31:0] r, data;
    ref_access(0, 1'b1, 3'd0, 32'h43, 32'hCAFE0011, e, r);
    xact(0, 1'b1, 3'd0, 32'h43, 32'hCAFE0011, lat, err, data, ok);
    n_total++;
    if ({lat, err} !== {32'd1, 1'b0}) begin
      $display("FAIL sb_ack: got lat %0d err %b expected lat 1 err 0", lat, err);
    end else n_pass++;
    for (int unsigned i = 0; i < 5; i++) begin
      ref_access(0, 1'b0, LANE_F3[i], LANE_AD[i], 32'h0, e, r);
      xact(0, 1'b0, LANE_F3[i], LANE_AD[i], 32'h0, lat, err, data, ok);
      n_total++;
      if ({lat, err, data} !== {32'd1, 1'b0, LANE_EXP[i]}) begin
        $display("FAIL lane%0d f3=%0d @%h: got lat %0d err %b data %h expected lat 1 err 0 data %h",
                 i, LANE_F3[i], LANE_AD[i], lat, err, data, LANE_EXP[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_latency3();
    int unsigned lat;
    logic e, err, ok, ev, er;
    logic [31:0] r, data;
    ref_access(1, 1'b1, 3'd2, 32'h40, 32'h0BADF00D, e, r);
    xact(1, 1'b1, 3'd2, 32'h40, 32'h0BADF00D, lat, err, data, ok);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_f3[1]    = 3'd2;
    req_addr[1]  = 32'h40;
    n_total++;
    if (req_ready[1] !== 1'b1) begin
      $display("FAIL l3_ready_pre: got %b expected 1", req_ready[1]);
    end else n_pass++;
    for (int unsigned s = 1; s <= 7; s++) begin
      @(posedge clk); #1;
      ev = (s == 3 || s == 6);
      er = !(s == 1 || s == 2 || s == 4 || s == 5);
      n_total++;
      if ({req_ready[1], rsp_valid[1], rsp_error[1], rsp_rdata[1]} !==
          {er, ev, 1'b0, ev ? 32'h0BADF00D : 32'h0}) begin
        $display("FAIL l3_edge%0d: got rdy/vld/err/data %b%b%b %h expected %b%b0 %h",
                 s, req_ready[1], rsp_valid[1], rsp_error[1], rsp_rdata[1],
                 er, ev, ev ? 32'h0BADF00D : 32'h0);
      end else n_pass++;
      if (s == 6) req_valid[1] = 1'b0;
    end
  endtask

  task automatic test_errors();
    int unsigned lat;
    logic e, err, ok;
    logic [31:0] r, data;
    logic        ew [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  ef [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
    logic [31:0] ea [4] = '{32'h41, 32'h45, 32'h40, 32'h400};
    ref_access(0, 1'b1, 3'd2, 32'h44, 32'h11223344, e, r);
    xact(0, 1'b1, 3'd2, 32'h44, 32'h11223344, lat, err, data, ok);
    ref_access(0, 1'b1, 3'd2, 32'h0, 32'hA5A5A5A5, e, r);
    xact(0, 1'b1, 3'd2, 32'h0, 32'hA5A5A5A5, lat, err, data, ok);
    for (int unsigned i = 0; i < 4; i++) begin
      ref_access(0, ew[i], ef[i], ea[i], 32'hFFFFFFFF, e, r);
      xact(0, ew[i], ef[i], ea[i], 32'hFFFFFFFF, lat, err, data, ok);
      n_total++;
      if ({lat, err, data} !== {32'd1, 1'b1, 32'h0}) begin
        $display("FAIL err%0d we=%b f3=%0d @%h: got lat %0d err %b data %h expected lat 1 err 1 data 0",
                 i, ew[i], ef[i], ea[i], lat, err, data);
      end else n_pass++;
    end
    xact(0, 1'b0, 3'd2, 32'h44, 32'h0, lat, err, data, ok);
    n_total++;
    if ({lat, err, data} !== {32'd1, 1'b0, 32'h11223344}) begin
      $display("FAIL err_unchanged44: got lat %0d err %b data %h expected 1 0 11223344", lat, err, data);
    end else n_pass++;
    xact(0, 1'b0, 3'd2, 32'h0, 32'h0, lat, err, data, ok);
    n_total++;
    if ({lat, err, data} !== {32'd1, 1'b0, 32'hA5A5A5A5}) begin
      $display("FAIL err_unchanged00: got lat %0d err %b data %h expected 1 0 a5a5a5a5", lat, err, data);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int unsigned lat;
    logic e, err, ok, seen;
    logic [31:0] r, data;
    ref_access(2, 1'b1, 3'd2, 32'h80, 32'h5EED1234, e, r);
    xact(2, 1'b1, 3'd2, 32'h80, 32'h5EED1234, lat, err, data, ok);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_f3[2]    = 3'd2;
    req_addr[2]  = 32'h80;
    n_total++;
    if (req_ready[2] !== 1'b1) begin
      $display("FAIL rst_mid_ready_pre: got %b expected 1", req_ready[2]);
    end else n_pass++;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if ({req_ready[2], rsp_valid[2]} !== 2'b00) begin
      $display("FAIL rst_mid_waiting: got rdy/vld %b%b expected 00", req_ready[2], rsp_valid[2]);
    end else n_pass++;
    rst[2] = 1'b1;
    #1;
    n_total++;
    if ({req_ready[2], rsp_valid[2], rsp_error[2], rsp_rdata[2]} !== {3'b100, 32'h0}) begin
      $display("FAIL rst_mid_state: got rdy/vld/err/data %b%b%b %h expected 100 0",
               req_ready[2], rsp_valid[2], rsp_error[2], rsp_rdata[2]);
    end else n_pass++;
    #2 rst[2] = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[2]) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) begin
      $display("FAIL rst_mid_no_rsp: got rsp_valid seen %b expected 0", seen);
    end else n_pass++;
    xact(2, 1'b0, 3'd2, 32'h80, 32'h0, lat, err, data, ok);
    n_total++;
    if ({lat, err, data, ok} !== {32'd4, 1'b0, 32'h5EED1234, 1'b1}) begin
      $display("FAIL rst_mid_reload: got lat %0d err %b data %h gate %b expected 4 0 5eed1234 1",
               lat, err, data, ok);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned lat;
    logic e, err, ok;
    logic [31:0] r, data;
    logic [31:0] w [3];
    for (int unsigned i = 0; i < 3; i++) w[i] = $urandom;
    for (int unsigned i = 0; i < 3; i++) begin
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_f3[0]    = 3'd2;
      req_addr[0]  = 32'(4 * i);
      req_wdata[0] = w[i];
      ref_access(0, 1'b1, 3'd2, 32'(4 * i), w[i], e, r);
      n_total++;
      if (req_ready[0] !== 1'b1) begin
        $display("FAIL b2b_ready%0d: got %b expected 1", i, req_ready[0]);
      end else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if ({rsp_valid[0], rsp_error[0], rsp_rdata[0]} !== {2'b10, 32'h0}) begin
        $display("FAIL b2b_ack%0d: got vld/err/data %b%b %h expected 10 0",
                 i, rsp_valid[0], rsp_error[0], rsp_rdata[0]);
      end else n_pass++;
    end
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({req_ready[0], rsp_valid[0]} !== 2'b10) begin
      $display("FAIL b2b_idle: got rdy/vld %b%b expected 10", req_ready[0], rsp_valid[0]);
    end else n_pass++;
    for (int unsigned i = 0; i < 3; i++) begin
      xact(0, 1'b0, 3'd2, 32'(4 * i), 32'h0, lat, err, data, ok);
      n_total++;
      if ({lat, err, data} !== {32'd1, 1'b0, w[i]}) begin
        $display("FAIL b2b_read%0d: got lat %0d err %b data %h expected 1 0 %h", i, lat, err, data, w[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_random();
    int unsigned lat, elat;
    logic e, err, ok, we;
    logic [2:0]  f;
    logic [31:0] a, wd, r, data;
    for (int unsigned d = 0; d < ND; d++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        wd = $urandom;
        ref_access(d, 1'b1, 3'd2, 32'(4 * k), wd, e, r);
        xact(d, 1'b1, 3'd2, 32'(4 * k), wd, lat, err, data, ok);
        n_total++;
        if ({lat, err} !== {32'd1, 1'b0}) begin
          $display("FAIL init dut%0d word %0d: got lat %0d err %b expected 1 0", d, k, lat, err);
        end else n_pass++;
      end
      for (int unsigned n = 0; n < 150; n++) begin
        if ((n_total - n_pass) > 40) break;
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 8) f = we ? 3'($urandom_range(0, 2)) : LEGAL_LD[$urandom_range(0, 4)];
        else f = 3'($urandom_range(0, 7));
        a = 32'($urandom_range(0, 4 * DEPTH - 1));
        if ($urandom_range(0, 3) != 0) a = a & ~(32'(acc_size(f)) - 32'd1);
        if ($urandom_range(0, 19) == 0) a = $urandom;
        wd = $urandom;
        ref_access(d, we, f, a, wd, e, r);
        elat = (!we && !e) ? lat_of(d) : 1;
        xact(d, we, f, a, wd, lat, err, data, ok);
        n_total++;
        if (lat !== elat) begin
          $display("FAIL rnd_lat dut%0d we=%b f3=%0d @%h: got %0d expected %0d", d, we, f, a, lat, elat);
        end else n_pass++;
        n_total++;
        if ({err, data} !== {e, r}) begin
          $display("FAIL rnd_rsp dut%0d we=%b f3=%0d @%h: got err %b data %h expected err %b data %h",
                   d, we, f, a, err, data, e, r);
        end else n_pass++;
        n_total++;
        if (ok !== 1'b1) begin
          $display("FAIL rnd_wait_gate dut%0d @%h: got %b expected 1", d, a, ok);
        end else n_pass++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned d = 0; d < ND; d++) begin
      rst[d]       = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_f3[d]    = 3'd0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    #2;
    test_reset();
    #10;
    for (int unsigned d = 0; d < ND; d++) rst[d] = 1'b0;
    @(posedge clk); #1;
    test_store_load();
    test_lanes();
    test_latency3();
    test_errors();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
